// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle: decode/execute/write_back status in,
// stall/bubble/flush control and controller status out.
interface hazard_ctrl_if;
    logic       dec_valid_i;
    logic [3:0] dec_rn_addr_i;
    logic       dec_rn_used_i;
    logic [3:0] dec_rm_addr_i;
    logic       dec_rm_used_i;
    logic       ex_valid_i;
    logic       ex_load_i;
    logic [3:0] ex_rd_addr_i;
    logic       branch_i;
    logic       pc_wb_i;
    logic       stall_fetch_o;
    logic       stall_decode_o;
    logic       bubble_exec_o;
    logic       flush_fetch_o;
    logic       flush_decode_o;
    logic [1:0] state_o;
    logic       stall_timeout_o;

    modport master (
        output dec_valid_i, dec_rn_addr_i, dec_rn_used_i, dec_rm_addr_i, dec_rm_used_i,
        output ex_valid_i, ex_load_i, ex_rd_addr_i, branch_i, pc_wb_i,
        input  stall_fetch_o, stall_decode_o, bubble_exec_o, flush_fetch_o, flush_decode_o,
        input  state_o, stall_timeout_o
    );

    modport slave (
        input  dec_valid_i, dec_rn_addr_i, dec_rn_used_i, dec_rm_addr_i, dec_rm_used_i,
        input  ex_valid_i, ex_load_i, ex_rd_addr_i, branch_i, pc_wb_i,
        output stall_fetch_o, stall_decode_o, bubble_exec_o, flush_fetch_o, flush_decode_o,
        output state_o, stall_timeout_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch/r15 flush windows and a
// stall watchdog that forces a one-slot release when a stall runs too long.
module hazard_ctrl #(
    parameter int LOAD_LAT     = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_STALL    = 15,
    parameter int CNT_W        = 4
) (
    input  logic         clk_i,
    input  logic         nreset_i,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LOAD_INIT  = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LIMIT  = CNT_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] stall_run_reg, stall_run_next;
    logic             rel_reg, rel_next;
    logic             timeout_reg, timeout_next;

    logic hit;
    logic ev;
    logic stall;
    logic flush;

    assign hit = hz.dec_valid_i & hz.ex_valid_i & hz.ex_load_i
               & ((hz.dec_rn_used_i & (hz.dec_rn_addr_i == hz.ex_rd_addr_i))
                | (hz.dec_rm_used_i & (hz.dec_rm_addr_i == hz.ex_rd_addr_i)));
    assign ev  = hz.pc_wb_i | hz.branch_i;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            stall_run_reg <= '0;
            rel_reg       <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            stall_run_reg <= stall_run_next;
            rel_reg       <= rel_next;
            timeout_reg   <= timeout_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        rel_next       = 1'b0;
        timeout_next   = timeout_reg;
        stall          = 1'b0;
        flush          = 1'b0;
        stall_run_next = '0;

        // An event (re)starts the flush window from any state; it never accumulates.
        if (ev) begin
            flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_next = FLUSH;
                cnt_next   = FLUSH_INIT;
            end else begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (hit && !rel_reg) begin
                        stall = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_next = LOAD_STALL;
                            cnt_next   = LOAD_INIT;
                        end
                    end
                end
                LOAD_STALL: begin
                    stall = 1'b1;
                    if (cnt_reg == CNT_ONE) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                end
                FLUSH: begin
                    flush = 1'b1;
                    if (cnt_reg == CNT_ONE) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end

        // Watchdog: the cycle that completes MAX_STALL stalled cycles forces a release slot.
        if (stall) begin
            stall_run_next = stall_run_reg + CNT_ONE;
            if (stall_run_next == RUN_LIMIT) begin
                state_next   = IDLE;
                cnt_next     = '0;
                rel_next     = 1'b1;
                timeout_next = 1'b1;
            end
        end

        if (!nreset_i) begin
            stall = 1'b0;
            flush = 1'b0;
        end
    end

    assign hz.stall_fetch_o   = stall;
    assign hz.stall_decode_o  = stall;
    assign hz.bubble_exec_o   = stall;
    assign hz.flush_fetch_o   = flush;
    assign hz.flush_decode_o  = flush;
    assign hz.state_o         = state_reg;
    assign hz.stall_timeout_o = timeout_reg;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (LOAD_LAT=2 and LOAD_LAT=3) share clock,
// reset and stimulus; each step drives inputs on the falling edge and checks Mealy outputs.
module tb_hazard_ctrl;
    logic clk;
    logic nrst;
    int   n_checks;
    int   n_fail;

    hazard_ctrl_if hz_a ();
    hazard_ctrl_if hz_b ();

    hazard_ctrl #(.LOAD_LAT(2), .FLUSH_CYCLES(2), .MAX_STALL(15), .CNT_W(4)) dut_a (
        .clk_i    (clk),
        .nreset_i (nrst),
        .hz       (hz_a)
    );

    hazard_ctrl #(.LOAD_LAT(3), .FLUSH_CYCLES(2), .MAX_STALL(15), .CNT_W(4)) dut_b (
        .clk_i    (clk),
        .nreset_i (nrst),
        .hz       (hz_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic dv, input logic [3:0] rn, input logic rnu,
                          input logic [3:0] rm, input logic rmu, input logic exv,
                          input logic ld, input logic [3:0] rd, input logic br,
                          input logic pw);
        hz_a.dec_valid_i = dv;   hz_b.dec_valid_i = dv;
        hz_a.dec_rn_addr_i = rn; hz_b.dec_rn_addr_i = rn;
        hz_a.dec_rn_used_i = rnu; hz_b.dec_rn_used_i = rnu;
        hz_a.dec_rm_addr_i = rm; hz_b.dec_rm_addr_i = rm;
        hz_a.dec_rm_used_i = rmu; hz_b.dec_rm_used_i = rmu;
        hz_a.ex_valid_i = exv;   hz_b.ex_valid_i = exv;
        hz_a.ex_load_i = ld;     hz_b.ex_load_i = ld;
        hz_a.ex_rd_addr_i = rd;  hz_b.ex_rd_addr_i = rd;
        hz_a.branch_i = br;      hz_b.branch_i = br;
        hz_a.pc_wb_i = pw;       hz_b.pc_wb_i = pw;
    endtask

    task automatic idle_in();
        set_in(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    // Load in execute writing r3, decode reads r3 as rn.
    task automatic hit_in(input logic br);
        set_in(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, br, 1'b0);
    endtask

    function automatic logic [7:0] obs_a();
        return {hz_a.stall_fetch_o, hz_a.stall_decode_o, hz_a.bubble_exec_o,
                hz_a.flush_fetch_o, hz_a.flush_decode_o, hz_a.state_o, hz_a.stall_timeout_o};
    endfunction

    function automatic logic [7:0] obs_b();
        return {hz_b.stall_fetch_o, hz_b.stall_decode_o, hz_b.bubble_exec_o,
                hz_b.flush_fetch_o, hz_b.flush_decode_o, hz_b.state_o, hz_b.stall_timeout_o};
    endfunction

    // Expected vector {stall_f, stall_d, bubble, flush_f, flush_d, state[1:0], timeout}.
    function automatic logic [7:0] ex(input logic s, input logic f, input logic [1:0] st,
                                      input logic to);
        return {s, s, s, f, f, st, to};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nrst     = 1'b0;
        idle_in();
        #3;
        chk("reset_a", obs_a(), ex(0, 0, 2'd0, 0));
        chk("reset_b", obs_b(), ex(0, 0, 2'd0, 0));
        cyc(); cyc();
        nrst = 1'b1;
        #1 chk("post_reset_a", obs_a(), ex(0, 0, 2'd0, 0));

        // Basic load-use on rn, LOAD_LAT=2.
        cyc(); hit_in(1'b0); #1 chk("t1_c1", obs_a(), ex(1, 0, 2'd0, 0));
        cyc();               #1 chk("t1_c2", obs_a(), ex(1, 0, 2'd1, 0));
        cyc(); set_in(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        #1 chk("t1_c3", obs_a(), ex(0, 0, 2'd0, 0));

        // Non-hits.
        cyc(); set_in(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
        #1 chk("t2_noload", obs_a(), ex(0, 0, 2'd0, 0));
        cyc(); set_in(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
        #1 chk("t2_rn_unused", obs_a(), ex(0, 0, 2'd0, 0));
        cyc(); set_in(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        #1 chk("t2_ex_invalid", obs_a(), ex(0, 0, 2'd0, 0));
        cyc(); set_in(1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
        #1 chk("t2_dec_invalid", obs_a(), ex(0, 0, 2'd0, 0));

        // Hit via rm, and r15 treated like any register.
        cyc(); set_in(1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0);
        #1 chk("t2_rm_c1", obs_a(), ex(1, 0, 2'd0, 0));
        cyc(); idle_in(); #1 chk("t2_rm_c2", obs_a(), ex(1, 0, 2'd1, 0));
        cyc();            #1 chk("t2_rm_c3", obs_a(), ex(0, 0, 2'd0, 0));
        cyc(); set_in(1'b1, 4'd15, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
        #1 chk("t2_r15_c1", obs_a(), ex(1, 0, 2'd0, 0));
        cyc(); idle_in(); #1 chk("t2_r15_c2", obs_a(), ex(1, 0, 2'd1, 0));
        cyc();            #1 chk("t2_r15_c3", obs_a(), ex(0, 0, 2'd0, 0));

        // Single branch -> two-cycle flush window.
        cyc(); set_in(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        #1 chk("t3_br_c1", obs_a(), ex(0, 1, 2'd0, 0));
        cyc(); idle_in(); #1 chk("t3_br_c2", obs_a(), ex(0, 1, 2'd2, 0));
        cyc();            #1 chk("t3_br_c3", obs_a(), ex(0, 0, 2'd0, 0));

        // Back-to-back branches reload, not extend.
        cyc(); set_in(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        #1 chk("t3_rl_c1", obs_a(), ex(0, 1, 2'd0, 0));
        cyc(); #1 chk("t3_rl_c2", obs_a(), ex(0, 1, 2'd2, 0));
        cyc(); idle_in(); #1 chk("t3_rl_c3", obs_a(), ex(0, 1, 2'd2, 0));
        cyc();            #1 chk("t3_rl_c4", obs_a(), ex(0, 0, 2'd0, 0));

        // pc_wb beats a same-cycle hit in IDLE.
        cyc(); set_in(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1);
        #1 chk("t3_pw_c1", obs_a(), ex(0, 1, 2'd0, 0));
        cyc(); idle_in(); #1 chk("t3_pw_c2", obs_a(), ex(0, 1, 2'd2, 0));
        cyc();            #1 chk("t3_pw_c3", obs_a(), ex(0, 0, 2'd0, 0));

        // pc_wb preempts LOAD_STALL.
        cyc(); hit_in(1'b0); #1 chk("t3_pre_c1", obs_a(), ex(1, 0, 2'd0, 0));
        cyc(); set_in(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1);
        #1 chk("t3_pre_c2", obs_a(), ex(0, 1, 2'd1, 0));
        cyc(); idle_in(); #1 chk("t3_pre_c3", obs_a(), ex(0, 1, 2'd2, 0));
        cyc();            #1 chk("t3_pre_c4", obs_a(), ex(0, 0, 2'd0, 0));
        cyc(); cyc();

        // Branch during second LOAD_STALL cycle, LOAD_LAT=3 instance.
        cyc(); hit_in(1'b0); #1 chk("t4_c1", obs_b(), ex(1, 0, 2'd0, 0));
        cyc();               #1 chk("t4_c2", obs_b(), ex(1, 0, 2'd1, 0));
        cyc(); hit_in(1'b1); #1 chk("t4_c3", obs_b(), ex(0, 1, 2'd1, 0));
        cyc(); hit_in(1'b0); #1 chk("t4_c4", obs_b(), ex(0, 1, 2'd2, 0));
        cyc(); idle_in();    #1 chk("t4_c5", obs_b(), ex(0, 0, 2'd0, 0));
        cyc(); cyc();

        // Watchdog with hit held constant.
        for (int i = 1; i <= 15; i++) begin
            cyc();
            if (i == 1) hit_in(1'b0);
            #1 chk($sformatf("t5_stall_%0d", i), obs_a(),
                   ex(1, 0, (i % 2 == 1) ? 2'd0 : 2'd1, 0));
        end
        cyc(); #1 chk("t5_release", obs_a(), ex(0, 0, 2'd0, 1));
        cyc(); #1 chk("t5_resume", obs_a(), ex(1, 0, 2'd0, 1));
        cyc(); idle_in(); #1 chk("t5_tail", obs_a(), ex(1, 0, 2'd1, 1));
        cyc();            #1 chk("t5_idle", obs_a(), ex(0, 0, 2'd0, 1));

        // Async reset during FLUSH with branch still asserted.
        cyc(); set_in(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        #1 chk("t6_c1", obs_a(), ex(0, 1, 2'd0, 1));
        cyc(); #1 chk("t6_c2", obs_a(), ex(0, 1, 2'd2, 1));
        nrst = 1'b0;
        #1 chk("t6_async", obs_a(), ex(0, 0, 2'd0, 0));
        chk("t6_cnt_in_reset", {4'd0, dut_a.cnt_reg}, 8'd0);
        cyc(); #1 chk("t6_held", obs_a(), ex(0, 0, 2'd0, 0));
        cyc(); idle_in(); nrst = 1'b1;
        #1 chk("t6_released", obs_a(), ex(0, 0, 2'd0, 0));
        chk("t6_cnt_after", {4'd0, dut_a.cnt_reg}, 8'd0);
        cyc(); hit_in(1'b0); #1 chk("t6_hit_after", obs_a(), ex(1, 0, 2'd0, 0));
        cyc(); idle_in(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
